// File: rtl/ivdivider_if.sv
// ---------------------------------------------------------------------------
// ivdivider_if
// Request/response bundle for the packed-SIMD divider.
//   flush_i   : synchronous abort of any in-flight operation
//   valid_i   : request valid            ready_o  : divider can accept
//   a_i, b_i  : packed dividends/divisors
//   op_i      : bit0 = signed, bit1 = remainder (0 = quotient)
//   size_i    : 0 = four byte lanes, 1 = two halfword lanes
//   valid_o   : result valid             ready_i  : consumer accepts result
//   result_o  : packed quotients or remainders
// slave modport faces the divider, master modport faces the requester.
// ---------------------------------------------------------------------------
interface ivdivider_if;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [1:0]  op_i;
    logic        size_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    modport slave (
        input  flush_i, valid_i, a_i, b_i, op_i, size_i, ready_i,
        output ready_o, valid_o, result_o
    );

    modport master (
        output flush_i, valid_i, a_i, b_i, op_i, size_i, ready_i,
        input  ready_o, valid_o, result_o
    );
endinterface

// File: rtl/ivdivider.sv
// ---------------------------------------------------------------------------
// ivdivider
// Multi-cycle packed-SIMD integer divide/remainder unit. Four 8-bit lanes or
// two 16-bit lanes, restoring division, one quotient bit per lane per cycle.
// Ports:
//   cpu_clock_i  : clock, rising edge
//   cpu_resetn_i : asynchronous active-low reset
//   bus          : ivdivider_if.slave request/response bundle
// Result appears 10 (bytes) or 18 (halfwords) edges after the accept edge.
// ---------------------------------------------------------------------------
module ivdivider (
    input  logic       cpu_clock_i,
    input  logic       cpu_resetn_i,
    ivdivider_if.slave bus
);

    localparam int unsigned W_DATA    = 32;
    localparam int unsigned W_CNT     = 4;
    localparam int unsigned N_LANES_B = 4;
    localparam int unsigned N_LANES_H = 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic                w_ld_req;
    logic                w_prep;
    logic                w_step;
    logic                w_fix;

    logic                r_ready;
    logic                r_valid;
    logic [W_DATA-1:0]   r_result;

    logic [W_DATA-1:0]   r_a;
    logic [W_DATA-1:0]   r_b;
    logic [1:0]          r_op;
    logic                r_size;
    logic [W_DATA-1:0]   r_dq;
    logic [W_DATA-1:0]   r_dvs;
    logic [W_DATA-1:0]   r_rem;
    logic [W_CNT-1:0]    r_cnt;

    logic [3:0]          w_neg_a;
    logic [3:0]          w_neg_b;
    logic [3:0]          w_dz;
    logic [W_DATA-1:0]   w_q_fix;
    logic [W_DATA-1:0]   w_r_fix;
    logic [W_DATA-1:0]   w_fix_result;
    logic [2*W_DATA-1:0] w_step_nx;

    // Per-lane sign bits; halfword mode uses bits [1:0] only.
    function automatic logic [3:0] sign_mask(input logic [W_DATA-1:0] v, input logic sz);
        logic [3:0] m;
        if (sz) m = {2'b00, v[31], v[15]};
        else    m = {v[31], v[23], v[15], v[7]};
        return m;
    endfunction

    // Per-lane zero detect; halfword mode uses bits [1:0] only.
    function automatic logic [3:0] zero_mask(input logic [W_DATA-1:0] v, input logic sz);
        logic [3:0] m;
        if (sz) m = {2'b00, v[31:16] == 16'd0, v[15:0] == 16'd0};
        else    m = {v[31:24] == 8'd0, v[23:16] == 8'd0, v[15:8] == 8'd0, v[7:0] == 8'd0};
        return m;
    endfunction

    // Two's-complement negate the lanes selected by m, modulo lane width.
    function automatic logic [W_DATA-1:0] neg_lanes(input logic [W_DATA-1:0] v,
                                                    input logic sz, input logic [3:0] m);
        logic [W_DATA-1:0] r;
        r = v;
        if (sz) begin
            for (int i = 0; i < int'(N_LANES_H); i++)
                if (m[i]) r[16*i +: 16] = 16'(~v[16*i +: 16] + 16'd1);
        end else begin
            for (int i = 0; i < int'(N_LANES_B); i++)
                if (m[i]) r[8*i +: 8] = 8'(~v[8*i +: 8] + 8'd1);
        end
        return r;
    endfunction

    // Take lanes from alt where m is set, otherwise from base.
    function automatic logic [W_DATA-1:0] merge_lanes(input logic [W_DATA-1:0] base,
                                                      input logic [W_DATA-1:0] alt,
                                                      input logic sz, input logic [3:0] m);
        logic [W_DATA-1:0] r;
        r = base;
        if (sz) begin
            for (int i = 0; i < int'(N_LANES_H); i++)
                if (m[i]) r[16*i +: 16] = alt[16*i +: 16];
        end else begin
            for (int i = 0; i < int'(N_LANES_B); i++)
                if (m[i]) r[8*i +: 8] = alt[8*i +: 8];
        end
        return r;
    endfunction

    // One restoring step per lane. The shifted partial remainder carries an
    // extra top bit so a lane never borrows from or carries into its neighbour.
    // Quotient bits shift into dq as the dividend bits shift out.
    function automatic logic [2*W_DATA-1:0] div_step(input logic [W_DATA-1:0] rem,
                                                     input logic [W_DATA-1:0] dq,
                                                     input logic [W_DATA-1:0] dvs,
                                                     input logic sz);
        logic [W_DATA-1:0] nrem;
        logic [W_DATA-1:0] ndq;
        logic [8:0]        sh8;
        logic [8:0]        df8;
        logic [16:0]       sh16;
        logic [16:0]       df16;
        nrem = rem;
        ndq  = dq;
        sh8  = '0;
        df8  = '0;
        sh16 = '0;
        df16 = '0;
        if (sz) begin
            for (int i = 0; i < int'(N_LANES_H); i++) begin
                sh16 = {rem[16*i +: 16], dq[16*i + 15]};
                df16 = 17'(sh16 - {1'b0, dvs[16*i +: 16]});
                if (!df16[16]) begin
                    nrem[16*i +: 16] = df16[15:0];
                    ndq[16*i +: 16]  = {dq[16*i +: 15], 1'b1};
                end else begin
                    nrem[16*i +: 16] = sh16[15:0];
                    ndq[16*i +: 16]  = {dq[16*i +: 15], 1'b0};
                end
            end
        end else begin
            for (int i = 0; i < int'(N_LANES_B); i++) begin
                sh8 = {rem[8*i +: 8], dq[8*i + 7]};
                df8 = 9'(sh8 - {1'b0, dvs[8*i +: 8]});
                if (!df8[8]) begin
                    nrem[8*i +: 8] = df8[7:0];
                    ndq[8*i +: 8]  = {dq[8*i +: 7], 1'b1};
                end else begin
                    nrem[8*i +: 8] = sh8[7:0];
                    ndq[8*i +: 8]  = {dq[8*i +: 7], 1'b0};
                end
            end
        end
        return {nrem, ndq};
    endfunction

    // Lane sign/zero info is always derived from the captured operands.
    always_comb begin
        w_neg_a      = sign_mask(r_a, r_size) & {4{r_op[0]}};
        w_neg_b      = sign_mask(r_b, r_size) & {4{r_op[0]}};
        w_dz         = zero_mask(r_b, r_size);
        w_step_nx    = div_step(r_rem, r_dq, r_dvs, r_size);
        // Divide-by-zero lanes bypass the sign fix-up entirely.
        w_q_fix      = merge_lanes(neg_lanes(r_dq, r_size, w_neg_a ^ w_neg_b),
                                   32'hFFFF_FFFF, r_size, w_dz);
        w_r_fix      = merge_lanes(neg_lanes(r_rem, r_size, w_neg_a), r_a, r_size, w_dz);
        w_fix_result = r_op[1] ? w_r_fix : w_q_fix;
    end

    // FSM state register.
    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) r_state <= S_IDLE;
        else               r_state <= w_state_nx;
    end

    // FSM next-state and datapath strobes; flush overrides everything.
    always_comb begin
        w_state_nx = r_state;
        w_ld_req   = 1'b0;
        w_prep     = 1'b0;
        w_step     = 1'b0;
        w_fix      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.valid_i) begin
                    w_ld_req   = 1'b1;
                    w_state_nx = S_PREP;
                end
            end
            S_PREP: begin
                w_prep     = 1'b1;
                w_state_nx = S_ITER;
            end
            S_ITER: begin
                w_step = 1'b1;
                if (r_cnt == '0) w_state_nx = S_FIX;
            end
            S_FIX: begin
                w_fix      = 1'b1;
                w_state_nx = S_DONE;
            end
            S_DONE: begin
                if (bus.ready_i) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (bus.flush_i) begin
            w_state_nx = S_IDLE;
            w_ld_req   = 1'b0;
            w_prep     = 1'b0;
            w_step     = 1'b0;
            w_fix      = 1'b0;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
        if (!cpu_resetn_i) begin
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_result <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_size   <= 1'b0;
            r_dq     <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
        end else begin
            r_ready <= (w_state_nx == S_IDLE);
            r_valid <= (w_state_nx == S_DONE);
            // Result is non-zero only while sitting in DONE.
            if (w_state_nx != S_DONE) r_result <= '0;
            else if (w_fix)           r_result <= w_fix_result;

            if (w_ld_req) begin
                r_a    <= bus.a_i;
                r_b    <= bus.b_i;
                r_op   <= bus.op_i;
                r_size <= bus.size_i;
            end
            if (w_prep) begin
                r_dq  <= neg_lanes(r_a, r_size, w_neg_a);
                r_dvs <= neg_lanes(r_b, r_size, w_neg_b);
                r_rem <= '0;
                r_cnt <= r_size ? W_CNT'(15) : W_CNT'(7);
            end
            if (w_step) begin
                r_rem <= w_step_nx[2*W_DATA-1:W_DATA];
                r_dq  <= w_step_nx[W_DATA-1:0];
                if (r_cnt != '0) r_cnt <= W_CNT'(r_cnt - W_CNT'(1));
            end
            if (bus.flush_i) r_cnt <= '0;
        end
    end

    assign bus.ready_o  = r_ready;
    assign bus.valid_o  = r_valid;
    assign bus.result_o = r_result;

endmodule

// File: tb/tb_ivdivider.sv
// ---------------------------------------------------------------------------
// tb_ivdivider
// Directed vectors for the packed-SIMD divider. Stimulus pushes expected
// results into a queue; a monitor pops and compares on each new valid_o,
// also checking latency, hold stability and the zero result outside DONE.
// ---------------------------------------------------------------------------
module tb_ivdivider;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        string       nm;
    } exp_t;

    logic  clk;
    logic  rst_n;
    int    cyc;
    int    n_cmp;
    int    n_err;
    exp_t  sb[$];

    ivdivider_if bus();

    ivdivider u_dut (
        .cpu_clock_i  (clk),
        .cpu_resetn_i (rst_n),
        .bus          (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Present one request in IDLE; optionally queue its expected result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input logic sz, input logic [31:0] exp, input bit push,
                         input string nm);
        exp_t e;
        @(negedge clk);
        bus.a_i     = a;
        bus.b_i     = b;
        bus.op_i    = op;
        bus.size_i  = sz;
        bus.valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        // Scramble operands to show they were captured on the accept edge.
        bus.a_i     = ~a;
        bus.b_i     = ~b;
        bus.op_i    = ~op;
        bus.size_i  = ~sz;
        check({nm, "_accept_ready"}, {31'b0, bus.ready_o}, 32'd0);
        if (push) begin
            e.res = exp;
            e.acc = cyc;
            e.lat = sz ? 18 : 10;
            e.nm  = nm;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!(sb.size() == 0 && bus.ready_o && !bus.valid_o) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: pending=%0d ready_o=%b expected drain", sb.size(), bus.ready_o);
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                       input logic sz, input logic [31:0] exp, input string nm);
        issue(a, b, op, sz, exp, 1'b1, nm);
        wait_done();
    endtask

    // Monitor: compare on the first cycle of each valid_o assertion.
    initial begin
        logic        prev_v;
        logic [31:0] prev_r;
        exp_t        e;
        prev_v = 1'b0;
        prev_r = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.valid_o && !prev_v) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", {31'b0, bus.valid_o}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check(e.nm, bus.result_o, e.res);
                        check({e.nm, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
                    end
                end else if (bus.valid_o) begin
                    check("hold_result", bus.result_o, prev_r);
                end else begin
                    check("idle_result_zero", bus.result_o, 32'd0);
                end
            end
            prev_v = bus.valid_o;
            prev_r = bus.result_o;
        end
    end

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        cyc         = 0;
        rst_n       = 1'b0;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.op_i    = '0;
        bus.size_i  = 1'b0;
        bus.ready_i = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, bus.ready_o}, 32'd1);
        check("rst_valid", {31'b0, bus.valid_o}, 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'b0, bus.ready_o}, 32'd1);

        // Basic lane arithmetic.
        run(32'h640AFF07, 32'h07031002, 2'b00, 1'b0, 32'h0E030F03, "b_uq");
        run(32'hFFF90011, 32'h0002FFFB, 2'b11, 1'b1, 32'hFFFF0002, "h_sr");
        run(32'hFFF90011, 32'h0002FFFB, 2'b01, 1'b1, 32'hFFFDFFFD, "h_sq");
        run(32'hF907800A, 32'h02FEFFFD, 2'b01, 1'b0, 32'hFDFD80FD, "b_sq");
        run(32'hF907800A, 32'h02FEFFFD, 2'b11, 1'b0, 32'hFF010001, "b_sr");
        run(32'hFFFF1234, 32'h01000010, 2'b00, 1'b1, 32'h00FF0123, "h_uq");
        run(32'hFFFF1234, 32'h01000010, 2'b10, 1'b1, 32'h00FF0004, "h_ur");

        // Divide by zero and signed overflow.
        run(32'h12345678, 32'h00000000, 2'b00, 1'b0, 32'hFFFFFFFF, "dz_uq");
        run(32'h12345678, 32'h00000000, 2'b10, 1'b0, 32'h12345678, "dz_ur");
        run(32'hF50A8001, 32'h00000000, 2'b01, 1'b0, 32'hFFFFFFFF, "dz_sq");
        run(32'hF50A8001, 32'h00000000, 2'b11, 1'b0, 32'hF50A8001, "dz_sr");
        run(32'h80008000, 32'hFFFF0001, 2'b01, 1'b1, 32'h80008000, "ovf_sq");
        run(32'h80008000, 32'hFFFF0001, 2'b11, 1'b1, 32'h00000000, "ovf_sr");

        // Flush during the fourth ITER cycle.
        issue(32'h640AFF07, 32'h07031002, 2'b00, 1'b0, 32'h0, 1'b0, "flush_iter");
        repeat (4) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_ready", {31'b0, bus.ready_o}, 32'd1);
        check("flush_valid", {31'b0, bus.valid_o}, 32'd0);
        repeat (20) @(negedge clk);
        run(32'h640AFF07, 32'h07031002, 2'b00, 1'b0, 32'h0E030F03, "after_flush");

        // Flush beats a simultaneous accept.
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.flush_i = 1'b0;
        check("flush_accept_ready", {31'b0, bus.ready_o}, 32'd1);
        repeat (20) @(negedge clk);

        // Consumer stall: result held for 5 cycles.
        bus.ready_i = 1'b0;
        issue(32'h80008000, 32'hFFFF0001, 2'b01, 1'b1, 32'h80008000, 1'b1, "hold");
        for (int k = 0; k < 40 && !bus.valid_o; k++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", {31'b0, bus.valid_o}, 32'd1);
            check("hold_ready", {31'b0, bus.ready_o}, 32'd0);
            @(negedge clk);
        end
        bus.ready_i = 1'b1;
        wait_done();
        check("hold_release_ready", {31'b0, bus.ready_o}, 32'd1);

        // Flush beats a result handshake in DONE.
        bus.ready_i = 1'b0;
        issue(32'h12345678, 32'h00000000, 2'b10, 1'b0, 32'h12345678, 1'b1, "flush_done");
        for (int k = 0; k < 40 && !bus.valid_o; k++) @(negedge clk);
        bus.ready_i = 1'b1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        check("flush_done_valid", {31'b0, bus.valid_o}, 32'd0);
        check("flush_done_ready", {31'b0, bus.ready_o}, 32'd1);
        wait_done();

        // Asynchronous reset in ITER.
        issue(32'hFFF90011, 32'h0002FFFB, 2'b11, 1'b1, 32'h0, 1'b0, "rst_iter");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'b0, bus.ready_o}, 32'd1);
        check("mid_rst_valid", {31'b0, bus.valid_o}, 32'd0);
        check("mid_rst_result", bus.result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("post_mid_rst_ready", {31'b0, bus.ready_o}, 32'd1);
        run(32'h640AFF07, 32'h07031002, 2'b00, 1'b0, 32'h0E030F03, "after_rst");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ivdivider.md
IVDIVIDER -- requirements
Module: ivdivider

Interface
Parameters: none.
REQ-001 The block SHALL be a multi-cycle packed-SIMD integer divider/remainder unit, four 8-bit lanes (size_i=0) or two 16-bit lanes (size_i=1), with the same lane packing as the packed adder.
REQ-002 Ports SHALL be:
- cpu_clock_i  in  1  sole clock, rising edge
- cpu_resetn_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous abort of any in-flight operation
- valid_i  in  1  request valid
- ready_o  out  1  block can accept a request
- a_i  in  32  packed dividends
- b_i  in  32  packed divisors
- op_i  in  2  bit0=signed, bit1=remainder (0=quotient)
- size_i  in  1  0=bytes, 1=halfwords
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- result_o  out  32  packed quotients or remainders

Function
REQ-003 A request SHALL be accepted on a rising edge where valid_i & ready_o & !flush_i; a_i, b_i, op_i, size_i SHALL be captured on that edge and ignored afterwards.
REQ-004 FSM states SHALL be IDLE, PREP, ITER, FIX, DONE; ready_o=1 only in IDLE.
REQ-005 IDLE->PREP on accept; PREP->ITER after 1 cycle; ITER lasts exactly N cycles (N=8 bytes, 16 halfwords), one quotient bit per lane per cycle, counter from N-1 down to 0; ITER->FIX when counter=0; FIX->DONE after 1 cycle.
REQ-006 PREP SHALL take absolute values of dividend and divisor per lane when op_i[0]=1; unsigned lanes pass through unchanged.
REQ-007 ITER SHALL implement restoring division per lane: shift remainder left by one bringing in next dividend MSB, trial-subtract |divisor|, set quotient bit if non-negative; lanes SHALL not interact (no carries across lane boundaries).
REQ-008 FIX SHALL negate quotient when signs of dividend and divisor differ, and negate remainder when dividend was negative (signed mode only), modulo lane width.
REQ-009 valid_o SHALL be 1 only in DONE; first assertion SHALL occur exactly N+2 rising edges after the accept edge (10 for bytes, 18 for halfwords).
REQ-010 DONE->IDLE on the edge where ready_i=1; while ready_i=0, valid_o and result_o SHALL hold stable.
REQ-011 result_o SHALL select quotient (op bit1=0) or remainder (op bit1=1) per the captured op; result_o outside DONE SHALL be 0.
REQ-012 Divide by zero per lane: quotient SHALL be all ones; remainder SHALL equal the original dividend lane, signed or unsigned.
REQ-013 Signed overflow per lane (dividend=lane MIN, divisor=-1): quotient SHALL be lane MIN (0x80/0x8000), remainder SHALL be 0.
REQ-014 flush_i=1 SHALL return the FSM to IDLE on the next edge from any state, clear valid_o, discard state; flush SHALL win over a simultaneous accept or result handshake.
REQ-015 A new request SHALL be accepted no earlier than the cycle after DONE->IDLE (no back-to-back overlap).

Reset
REQ-016 On cpu_resetn_i=0 the block SHALL asynchronously enter IDLE with ready_o=1, valid_o=0, result_o=0, counter and lane registers 0, including mid-operation; no result from the aborted op SHALL ever appear.
REQ-017 Outputs SHALL leave reset values only on a clock edge after cpu_resetn_i deasserts.

Verification
REQ-018 Bytes unsigned quotient: a=0x640AFF07, b=0x07031002, op=00 -> result_o=0x0E030F03, valid_o 10 edges after accept.
REQ-019 Halfwords signed remainder: a=0xFFF90011, b=0x0002FFFB, op=11 -> result_o=0xFFFF0002, valid_o 18 edges after accept.
REQ-020 Divide by zero, bytes: a=0x12345678, b=0x00000000, op=00 -> 0xFFFFFFFF; op=10 -> 0x12345678.
REQ-021 Signed overflow, halfwords: a=0x80008000, b=0xFFFF0001, op=01 -> 0x80008000; op=11 -> 0x00000000.
REQ-022 flush_i pulse in ITER cycle 4 -> valid_o never asserts, ready_o=1 next cycle; following request returns correct result with nominal latency.
REQ-023 Hold ready_i=0 for 5 cycles in DONE -> valid_o=1 and result_o stable, ready_o=0 throughout; cpu_resetn_i pulse in ITER -> immediate IDLE, valid_o=0.
